// File: rtl/instr_trace_emitter.sv
// Instruction trace producer: queues one record per retired instruction and
// serializes each record as a 23-byte framed stream over a valid/ready byte link.
module instr_trace_emitter #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_valid,
    input  logic [15:0] full_op_code,
    input  logic [4:0]  rs1_sel_zimm,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  rs2_sel,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_sel,
    input  logic [31:0] rd_data,
    input  logic [31:0] imm_csr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fifo_full,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [4:0]    LAST_IDX   = 5'd22;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    typedef struct packed {
        logic        drop;
        logic [15:0] op;
        logic [4:0]  rs1_sel;
        logic [31:0] rs1_data;
        logic [4:0]  rs2_sel;
        logic [31:0] rs2_data;
        logic [4:0]  rd_sel;
        logic [31:0] rd_data;
        logic [31:0] imm;
    } rec_t;

    rec_t            mem [FIFO_DEPTH];
    rec_t            in_rec;
    rec_t            frame;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [1:0]      state;
    logic [4:0]      idx;
    logic [7:0]      chk;
    logic [7:0]      cur_byte;
    logic            pend_drop;
    logic            push;
    logic            reject;
    logic            pop;
    logic            hs;

    always_comb begin
        in_rec.drop     = pend_drop;
        in_rec.op       = full_op_code;
        in_rec.rs1_sel  = rs1_sel_zimm;
        in_rec.rs1_data = rs1_data;
        in_rec.rs2_sel  = rs2_sel;
        in_rec.rs2_data = rs2_data;
        in_rec.rd_sel   = rd_sel;
        in_rec.rd_data  = rd_data;
        in_rec.imm      = imm_csr;
    end

    // A full FIFO rejects even when a pop happens in the same cycle.
    assign fifo_full = (count == FULL_COUNT);
    assign push      = trace_valid && !fifo_full;
    assign reject    = trace_valid && fifo_full;
    assign pop       = (state == ST_LOAD) && (count != '0);
    assign hs        = tx_valid && tx_ready;

    // NOTE: storage arrays carry no reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_rec;
        end
    end

    // The frame copy lets the FIFO slot be reused while the frame is still sent.
    always_ff @(posedge clk) begin
        if (pop) begin
            frame <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pend_drop <= 1'b0;
            drop_cnt  <= '0;
            state     <= ST_IDLE;
            idx       <= '0;
            chk       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase

            if (reject) begin
                pend_drop <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (push) begin
                pend_drop <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    idx <= '0;
                    chk <= '0;
                    state <= pop ? ST_SEND : ST_IDLE;
                end
                ST_SEND: begin
                    if (hs) begin
                        chk <= chk ^ cur_byte;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ((count != '0) || push) ? ST_LOAD : ST_IDLE;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Byte 22 is the running XOR accumulated over the 22 bytes already accepted.
    always_comb begin
        cur_byte = chk;
        case (idx)
            5'd0:    cur_byte = frame.drop ? (SYNC + 8'd1) : SYNC;
            5'd1:    cur_byte = frame.op[7:0];
            5'd2:    cur_byte = frame.op[15:8];
            5'd3:    cur_byte = {3'b000, frame.rs1_sel};
            5'd4:    cur_byte = frame.rs1_data[7:0];
            5'd5:    cur_byte = frame.rs1_data[15:8];
            5'd6:    cur_byte = frame.rs1_data[23:16];
            5'd7:    cur_byte = frame.rs1_data[31:24];
            5'd8:    cur_byte = {3'b000, frame.rs2_sel};
            5'd9:    cur_byte = frame.rs2_data[7:0];
            5'd10:   cur_byte = frame.rs2_data[15:8];
            5'd11:   cur_byte = frame.rs2_data[23:16];
            5'd12:   cur_byte = frame.rs2_data[31:24];
            5'd13:   cur_byte = {3'b000, frame.rd_sel};
            5'd14:   cur_byte = frame.rd_data[7:0];
            5'd15:   cur_byte = frame.rd_data[15:8];
            5'd16:   cur_byte = frame.rd_data[23:16];
            5'd17:   cur_byte = frame.rd_data[31:24];
            5'd18:   cur_byte = frame.imm[7:0];
            5'd19:   cur_byte = frame.imm[15:8];
            5'd20:   cur_byte = frame.imm[23:16];
            5'd21:   cur_byte = frame.imm[31:24];
            default: cur_byte = chk;
        endcase
    end

    assign tx_valid = (state == ST_SEND);
    assign tx_data  = tx_valid ? cur_byte : 8'h00;
    assign busy     = (state != ST_IDLE) || (count != '0);

endmodule
